// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/operand/result bundle between the ALU sequencer and its client.
interface alu_sequencer_if #(parameter int WIDTH = 8);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] acc_in;
   logic [WIDTH-1:0] bus_in;
   logic             busy;
   logic             done;
   logic             acc_we;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   modport master (output start, op, acc_in, bus_in,
                   input  busy, done, acc_we, result, zero, carry, overflow);
   modport slave  (input  start, op, acc_in, bus_in,
                   output busy, done, acc_we, result, zero, carry, overflow);
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU (single-cycle logic/arith, iterative shift, shift-add multiply) feeding the accumulator.
module alu_sequencer #(parameter int WIDTH = 8) (
   input logic CLK,
   input logic RESET,
   alu_sequencer_if.slave io
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                          OP_XOR = 3'd4, OP_SHL = 3'd6, OP_MUL = 3'd7;
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL, S_DONE} state_t;
   state_t             r_state;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_result;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand, r_prod;
   logic               r_busy, r_done, r_zero, r_carry, r_overflow;
   logic [WIDTH:0]     w_sum, w_diff;
   logic [WIDTH-1:0]   w_res, w_shl;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_c, w_v;
   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, r_b};
      w_diff = {1'b0, r_a} - {1'b0, r_b};
      w_res  = r_op == OP_ADD ? w_sum[WIDTH-1:0] :
               r_op == OP_SUB ? w_diff[WIDTH-1:0] :
               r_op == OP_AND ? r_a & r_b :
               r_op == OP_OR  ? r_a | r_b :
               r_op == OP_XOR ? r_a ^ r_b : ~r_a;
      w_c    = r_op == OP_ADD ? w_sum[WIDTH] : r_op == OP_SUB ? w_diff[WIDTH] : 1'b0;
      w_v    = r_op == OP_ADD ? (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]) :
               r_op == OP_SUB ? (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]) : 1'b0;
      // a zero shift count passes A through untouched
      w_shl  = r_cnt == '0 ? r_a : {r_a[WIDTH-2:0], 1'b0};
      w_prod = r_prod + (r_b[0] ? r_mcand : '0);
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         r_mcand    <= '0;
         r_prod     <= '0;
         r_result   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_zero     <= 1'b0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (io.start) begin
               r_op    <= io.op;
               r_a     <= io.acc_in;
               r_b     <= io.bus_in;
               r_cnt   <= io.op == OP_SHL ? CW'(io.bus_in[2:0]) : CW'(WIDTH);
               r_mcand <= {{WIDTH{1'b0}}, io.acc_in};
               r_prod  <= '0;
               r_busy  <= 1'b1;
               r_state <= io.op == OP_SHL ? S_SHIFT : io.op == OP_MUL ? S_MUL : S_EXEC;
            end
            S_EXEC: begin
               r_result   <= w_res;
               r_zero     <= w_res == '0;
               r_carry    <= w_c;
               r_overflow <= w_v;
               r_done     <= 1'b1;
               r_state    <= S_DONE;
            end
            S_SHIFT: if (r_cnt <= CW'(1)) begin
               r_result   <= w_shl;
               r_zero     <= w_shl == '0;
               r_carry    <= r_cnt != '0 && r_a[WIDTH-1];
               r_overflow <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= S_DONE;
            end else begin
               r_a   <= w_shl;
               r_cnt <= r_cnt - CW'(1);
            end
            S_MUL: begin
               r_prod  <= w_prod;
               r_mcand <= r_mcand << 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result   <= w_prod[WIDTH-1:0];
                  r_zero     <= w_prod[WIDTH-1:0] == '0;
                  r_carry    <= 1'b0;
                  r_overflow <= |w_prod[2*WIDTH-1:WIDTH];
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign io.busy     = r_busy;
   assign io.done     = r_done;
   assign io.acc_we   = r_done;
   assign io.result   = r_result;
   assign io.zero     = r_zero;
   assign io.carry    = r_carry;
   assign io.overflow = r_overflow;
endmodule
